program_loader: RTL and testbench

Sequences and arbitrates the shared MAR/RAM write path between the CPU control logic and an external byte-stream load port. While idle, the CPU's MI/RI strobes and bus value pass straight through to MAR and RAM. When a load is started, the loader stops the CPU clock and writes a block of bytes into RAM starting at address 0. It then pulses CPU reset and hands the RAM back. It sits between the control logic / bus and the MAR/RAM registers, and drives the enable on control_clk.

---
 rtl/program_loader_pkg.sv | 14 +
 rtl/binary_counter.sv | 20 ++
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and default widths for the MAR/RAM write path and the program loader.
package program_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        RELEASE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/binary_counter.sv
// Free-running binary up-counter with synchronous clear and count enable.
module binary_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Arbitrates the MAR/RAM write path between the CPU and a byte-stream load port,
// holding the CPU clock off while a block is written from address 0 upward.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              cpu_MI,
    input  logic              cpu_RI,
    input  logic [DATA_W-1:0] cpu_bus,
    output logic              mar_we,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_run,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(1) << ADDR_W;

    loader_state_t     state;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr;
    logic              start;
    logic              accept;

    assign start  = (state == IDLE) && load_start;
    assign accept = (state == DATA) && load_valid;

    binary_counter #(.W(ADDR_W)) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (accept),
        .count (addr)
    );

    // State, remaining byte count and the registered completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == RELEASE);
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= ADDR;
                        remaining <= (load_len == '0) ? FULL_LEN : {1'b0, load_len};
                    end
                end
                ADDR: state <= DATA;
                DATA: begin
                    if (load_valid) begin
                        remaining <= remaining - CNT_W'(1);
                        state     <= (remaining == CNT_W'(1)) ? RELEASE : ADDR;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write-path mux and control outputs decoded from the current state.
    always_comb begin
        mar_we     = 1'b0;
        mar_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        load_ready = 1'b0;
        cpu_run    = 1'b0;
        cpu_rst    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                mar_we    = cpu_MI;
                mar_addr  = cpu_bus[ADDR_W-1:0];
                ram_we    = cpu_RI;
                ram_wdata = cpu_bus;
                cpu_run   = 1'b1;
                busy      = 1'b0;
            end
            ADDR: begin
                mar_we   = 1'b1;
                mar_addr = addr;
            end
            DATA: begin
                load_ready = 1'b1;
                ram_we     = load_valid;
                ram_wdata  = load_data;
            end
            RELEASE: cpu_rst = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected MAR/RAM writes are queued by the stimulus
// and popped by an independent monitor; a small MAR/RAM model checks final memory contents.
module tb_program_loader;

    typedef struct packed {
        logic       is_ram;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic [3:0] load_len;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       cpu_MI;
    logic       cpu_RI;
    logic [7:0] cpu_bus;
    logic       mar_we;
    logic [3:0] mar_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic       cpu_run;
    logic       cpu_rst;
    logic       busy;
    logic       done;

    exp_t       exp_q[$];
    logic [7:0] ram_model[16];
    logic [3:0] mar_model;
    logic [7:0] pat[16];
    int         n_checks;
    int         n_fail;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cpu_MI     (cpu_MI),
        .cpu_RI     (cpu_RI),
        .cpu_bus    (cpu_bus),
        .mar_we     (mar_we),
        .mar_addr   (mar_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .cpu_run    (cpu_run),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    initial begin : monitor
        exp_t e;
        mar_model = '0;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ram_write: unexpected ram_we data 0x%0h", ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_ram || e.val !== ram_wdata) begin
                        n_fail++;
                        $display("FAIL ram_write: got ram 0x%0h, expected %s 0x%0h",
                                 ram_wdata, e.is_ram ? "ram" : "mar", e.val);
                    end
                end
                ram_model[mar_model] = ram_wdata;
            end
            if (mar_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mar_write: unexpected mar_we addr 0x%0h", mar_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_ram || e.val !== {4'h0, mar_addr}) begin
                        n_fail++;
                        $display("FAIL mar_write: got mar 0x%0h, expected %s 0x%0h",
                                 mar_addr, e.is_ram ? "ram" : "mar", e.val);
                    end
                end
                mar_model = mar_addr;
            end
        end
    end

    // One load session: queues the expected writes, drives bytes, and measures timing.
    task automatic run_load(input logic [3:0] len_f, input int nbytes, input logic [7:0] key,
                            input int stall_n, input bit noise,
                            output int run_low, output int rst_hi,
                            output int done_at, output int done_cnt);
        int idx;
        int stall_left;
        bit acc;
        idx        = 0;
        stall_left = stall_n;
        run_low    = 0;
        rst_hi     = 0;
        done_at    = -1;
        done_cnt   = 0;
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back({1'b0, 8'(i % 16)});
            exp_q.push_back({1'b1, pat[i] ^ key});
        end
        load_len   = len_f;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = pat[0] ^ key;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) begin
                load_start = noise && busy && (c == 3);
                if (noise && busy) begin
                    cpu_MI  = c[0];
                    cpu_RI  = !c[0];
                    cpu_bus = 8'hFF;
                end else begin
                    cpu_MI = 1'b0;
                    cpu_RI = 1'b0;
                end
                load_valid = 1'b1;
                if (stall_left > 0 && idx == 1 && load_ready) begin
                    load_valid = 1'b0;
                    stall_left--;
                end
                if (idx < nbytes) load_data = pat[idx] ^ key;
            end
            #1;
            if (!load_valid && load_ready) check("stall_no_ram_we", ram_we, 0);
            if (!cpu_run) run_low++;
            if (cpu_rst) rst_hi++;
            if (done) begin
                if (done_cnt == 0) done_at = c;
                done_cnt++;
            end
            acc = load_valid && load_ready;
            if (done_at >= 0 && c >= done_at + 2) break;
            step();
            if (acc) idx++;
        end
        load_start = 1'b0;
        load_valid = 1'b0;
        cpu_MI     = 1'b0;
        cpu_RI     = 1'b0;
        cpu_bus    = '0;
        for (int i = 0; i < nbytes; i++) check("ram_contents", ram_model[i], pat[i] ^ key);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int run_low, rst_hi, done_at, done_cnt;
        n_checks   = 0;
        n_fail     = 0;
        for (int i = 0; i < 16; i++) pat[i] = 8'(17 * (i + 1));
        for (int i = 0; i < 16; i++) ram_model[i] = '0;
        rst        = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        cpu_MI     = 1'b0;
        cpu_RI     = 1'b0;
        cpu_bus    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_cpu_run", cpu_run, 1);
        check("reset_cpu_rst", cpu_rst, 0);
        check("reset_done", done, 0);
        check("reset_load_ready", load_ready, 0);
        check("reset_mar_we", mar_we, 0);
        check("reset_ram_we", ram_we, 0);

        // Idle passthrough of CPU strobes.
        step();
        exp_q.push_back({1'b0, 8'h0A});
        cpu_MI  = 1'b1;
        cpu_bus = 8'h2A;
        #1;
        check("idle_mar_addr", mar_addr, 4'hA);
        check("idle_cpu_run", cpu_run, 1);
        step();
        exp_q.push_back({1'b1, 8'h5C});
        cpu_MI  = 1'b0;
        cpu_RI  = 1'b1;
        cpu_bus = 8'h5C;
        #1;
        check("idle_ram_wdata", ram_wdata, 8'h5C);
        check("idle_load_ready", load_ready, 0);
        step();
        cpu_RI  = 1'b0;
        cpu_bus = '0;
        step();

        // Three bytes, valid held high.
        run_load(4'd3, 3, 8'h00, 0, 1'b0, run_low, rst_hi, done_at, done_cnt);
        check("len3_run_low", run_low, 7);
        check("len3_rst_hi", rst_hi, 1);
        check("len3_done_at", done_at, 8);
        check("len3_done_cnt", done_cnt, 1);
        step();

        // Two bytes with a five-cycle stall after the first.
        run_load(4'd2, 2, 8'hA5, 5, 1'b0, run_low, rst_hi, done_at, done_cnt);
        check("stall_run_low", run_low, 10);
        check("stall_done_at", done_at, 11);
        check("stall_done_cnt", done_cnt, 1);
        step();

        // Full depth with CPU strobe noise and a repeated load_start during the session.
        run_load(4'd0, 16, 8'h3C, 0, 1'b1, run_low, rst_hi, done_at, done_cnt);
        check("full_run_low", run_low, 33);
        check("full_rst_hi", rst_hi, 1);
        check("full_done_at", done_at, 34);
        check("full_done_cnt", done_cnt, 1);
        check("full_idle_after", busy, 0);
        step();

        // Reset after two accepted bytes, during the third ADDR cycle.
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'hE1});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'hE2});
        exp_q.push_back({1'b0, 8'h02});
        load_len   = 4'd4;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hE1;
        step();
        load_start = 1'b0;
        step();
        check("rst_mid_ready", load_ready, 1);
        step();
        load_data = 8'hE2;
        step();
        step();
        load_data = 8'hE3;
        check("rst_mid_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        load_valid = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cpu_run", cpu_run, 1);
        check("rst_mid_cpu_rst", cpu_rst, 0);
        check("rst_mid_done", done, 0);
        step();
        check("rst_mid_done_next", done, 0);
        check("rst_mid_ram0", ram_model[0], 8'hE1);
        check("rst_mid_ram1", ram_model[1], 8'hE2);

        // Reset and load_start in the same cycle.
        rst        = 1'b1;
        load_start = 1'b1;
        load_len   = 4'd3;
        step();
        rst        = 1'b0;
        load_start = 1'b0;
        #1;
        check("rst_start_busy", busy, 0);
        check("rst_start_cpu_run", cpu_run, 1);
        check("rst_start_ready", load_ready, 0);
        step();
        check("rst_start_busy_next", busy, 0);
        check("rst_start_done", done, 0);
        step();

        check("exp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
